// File: rtl/aes_dec_key_sched.sv
// ============================================================================
// aes_dec_key_sched
// ----------------------------------------------------------------------------
// Decryption-side AES-128 key schedule. A 128-bit cipher key is accepted in
// IDLE and expanded into 11 round keys, one per cycle (EXPAND). The keys are
// then streamed out in reverse order, round 10 first and round 0 last
// (STREAM), over a valid/ready handshake.
//
// Optional feature macro: AES_DEC_KEY_REPLAY_EN
//   When defined, a `replay` input re-streams the last fully delivered key
//   set without re-expanding it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   key_in     cipher key, key_in[127:96] = w0 (FIPS-197 byte order)
//   key_valid  key_in is valid
//   key_ready  block can accept a key (IDLE only)
//   rk_out     current round key, same byte order as key_in
//   rk_index   round number of rk_out (10 down to 0)
//   rk_valid   rk_out / rk_index are valid
//   rk_ready   consumer accepts the current round key
//   busy       high in EXPAND or STREAM
//   replay     (AES_DEC_KEY_REPLAY_EN only) re-stream stored keys
// ============================================================================

// ----------------------------------------------------------------------------
// sbox: combinational AES S-box (8-bit in, 8-bit out).
// Multiplicative inverse in GF(2^8) computed as a^254, followed by the
// FIPS-197 affine transform. a^254 maps 0 to 0, as the S-box requires.
// ----------------------------------------------------------------------------
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] s;
      p = '0;
      s = x;
      for (int unsigned i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] pw;
   logic [7:0] inv;

   // a^254 = a^2 * a^4 * ... * a^128
   always_comb begin
      pw  = gmul(a, a);
      inv = pw;
      for (int unsigned k = 2; k < 8; k++) begin
         pw  = gmul(pw, pw);
         inv = gmul(inv, pw);
      end
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// ----------------------------------------------------------------------------
// aes_dec_key_sched: top level
// ----------------------------------------------------------------------------
module aes_dec_key_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_index,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy
`ifdef AES_DEC_KEY_REPLAY_EN
   ,
   input  logic         replay
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXPAND = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;

   logic [1:0]   state;
   logic [3:0]   cnt;
   logic [3:0]   idx;
   logic [127:0] rk [0:10];

`ifdef AES_DEC_KEY_REPLAY_EN
   logic         keys_valid;
`endif

   // ------------------------------------------------------------------------
   // Round step: rk[cnt] = step(rk[cnt-1], rcon[cnt])
   // ------------------------------------------------------------------------
   logic [127:0] prev_rk;
   logic [127:0] next_rk;
   logic [31:0]  rot_w3;
   logic [31:0]  sub_w;
   logic [31:0]  t;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [7:0]   rcon;

   always_comb begin
      prev_rk = rk[cnt - 4'd1];
      rot_w3  = {prev_rk[23:0], prev_rk[31:24]};
   end

   sbox u_sb3 (.a(rot_w3[31:24]), .y(sub_w[31:24]));
   sbox u_sb2 (.a(rot_w3[23:16]), .y(sub_w[23:16]));
   sbox u_sb1 (.a(rot_w3[15:8]),  .y(sub_w[15:8]));
   sbox u_sb0 (.a(rot_w3[7:0]),   .y(sub_w[7:0]));

   always_comb begin
      case (cnt)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
      t       = sub_w ^ {rcon, 24'h000000};
      w0n     = prev_rk[127:96] ^ t;
      w1n     = prev_rk[95:64]  ^ w0n;
      w2n     = prev_rk[63:32]  ^ w1n;
      w3n     = prev_rk[31:0]   ^ w2n;
      next_rk = {w0n, w1n, w2n, w3n};
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
`ifdef AES_DEC_KEY_REPLAY_EN
         keys_valid <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (key_valid) begin
                  cnt   <= 4'd1;
                  state <= EXPAND;
`ifdef AES_DEC_KEY_REPLAY_EN
                  // rk[0] is about to be overwritten, so the stored set is stale
                  keys_valid <= 1'b0;
               end else if (replay && keys_valid) begin
                  idx   <= 4'd10;
                  state <= STREAM;
`endif
               end
            end
            EXPAND: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd10) begin
                  idx   <= 4'd10;
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (rk_ready) begin
                  if (idx == 4'd0) begin
                     state <= IDLE;
`ifdef AES_DEC_KEY_REPLAY_EN
                     keys_valid <= 1'b1;
`endif
                  end else begin
                     idx <= idx - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Round-key storage carries no reset; its contents are only read in STREAM.
   always_ff @(posedge clk) begin
      if (state == IDLE && key_valid) begin
         rk[0] <= key_in;
      end else if (state == EXPAND) begin
         rk[cnt] <= next_rk;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from state registers only
   // ------------------------------------------------------------------------
   always_comb begin
      key_ready = (state == IDLE);
      busy      = (state != IDLE);
      rk_valid  = (state == STREAM);
      rk_out    = rk_valid ? rk[idx] : '0;
      rk_index  = rk_valid ? idx : '0;
   end

endmodule
